// File: rtl/store_buffer.sv
// Store buffer: reads len+1 words from SRAM and writes them to DRAM as one
// AXI INCR burst, with a bounded number of burst re-sends on error responses.
module store_buffer #(
    parameter int unsigned DW        = 32,
    parameter int unsigned SRAM_AW   = 8,
    parameter int unsigned DRAM_AW   = 12,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned MAX_RETRY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_store_vld,
    output logic               ctrl_store_rdy,
    input  logic [ID_W-1:0]    ctrl_store_id,
    input  logic [DRAM_AW-1:0] ctrl_store_dram_addr,
    input  logic [7:0]         ctrl_store_len,
    input  logic [2:0]         ctrl_store_size,
    input  logic [SRAM_AW-1:0] ctrl_store_st_addr,
    input  logic [1:0]         ctrl_store_sram_type,
    output logic               store_sram_vld,
    output logic [SRAM_AW-1:0] store_sram_addr,
    output logic [1:0]         store_sram_type,
    input  logic [DW-1:0]      sram_store_dout,
    output logic [ID_W-1:0]    store_axi_awid,
    output logic [DRAM_AW-1:0] store_axi_awaddr,
    output logic [7:0]         store_axi_awlen,
    output logic [2:0]         store_axi_awsize,
    output logic [1:0]         store_axi_awburst,
    output logic               store_axi_awvld,
    input  logic               ctrl_dram_awrdy,
    output logic [DW-1:0]      store_axi_wdata,
    output logic [DW/8-1:0]    store_axi_wstrb,
    output logic               store_axi_wlast,
    output logic               store_axi_wvld,
    input  logic               ctrl_dram_wrdy,
    input  logic [ID_W-1:0]    ctrl_dram_bid,
    input  logic [1:0]         ctrl_dram_bresp,
    input  logic               ctrl_dram_bvld,
    output logic               store_axi_brdy,
    output logic               store_done,
    output logic               store_err
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 9;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_DATA, S_RESP, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DRAM_AW-1:0]   daddr_q, daddr_d;
    logic [7:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [SRAM_AW-1:0]   st_addr_q, st_addr_d;
    logic [1:0]           type_q, type_d;
    logic [CW-1:0]        reads_q, reads_d;
    logic [CW-1:0]        beats_q, beats_d;
    logic [1:0][DW-1:0]   fifo_q, fifo_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 inflight_q, inflight_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 err_q, err_d;

    logic                 fifo_empty_c, last_beat_c, read_en_c, wvld_c;
    logic                 pop_c, pop_fifo_c, push_c, clear_c;
    logic [SW-1:0]        strb_c;

    // Next-state: FSM, read issue, fall-through FIFO and beat counting
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        daddr_d    = daddr_q;
        len_d      = len_q;
        size_d     = size_q;
        st_addr_d  = st_addr_q;
        type_d     = type_q;
        reads_d    = reads_q;
        beats_d    = beats_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        err_d      = err_q;
        clear_c    = 1'b0;

        fifo_empty_c = (cnt_q == 2'd0);
        last_beat_c  = (beats_q == {1'b0, len_q});
        read_en_c    = (state_q == S_DATA) && (reads_q <= {1'b0, len_q}) &&
                       ((3'(cnt_q) + 3'(inflight_q)) < 3'd2);
        // SRAM data in flight is offered directly when the FIFO is empty
        wvld_c       = (state_q == S_DATA) && (!fifo_empty_c || inflight_q);
        pop_c        = wvld_c && ctrl_dram_wrdy;
        pop_fifo_c   = pop_c && !fifo_empty_c;
        push_c       = inflight_q && !(pop_c && fifo_empty_c);

        inflight_d = read_en_c;
        if (read_en_c) reads_d = reads_q + CW'(1);
        if (pop_c)     beats_d = beats_q + CW'(1);
        if (push_c) begin
            fifo_d[wr_ptr_q] = sram_store_dout;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_fifo_c) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + 2'(push_c) - 2'(pop_fifo_c);

        unique case (size_q)
            3'd0:    strb_c = SW'(1);
            3'd1:    strb_c = SW'(3);
            default: strb_c = '1;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_store_vld) begin
                    id_d      = ctrl_store_id;
                    daddr_d   = ctrl_store_dram_addr;
                    len_d     = ctrl_store_len;
                    size_d    = ctrl_store_size;
                    st_addr_d = ctrl_store_st_addr;
                    type_d    = ctrl_store_sram_type;
                    retry_d   = '0;
                    err_d     = 1'b0;
                    clear_c   = 1'b1;
                    state_d   = S_AW;
                end
            end
            S_AW: begin
                if (ctrl_dram_awrdy) state_d = S_DATA;
            end
            S_DATA: begin
                if (pop_c && last_beat_c) state_d = S_RESP;
            end
            S_RESP: begin
                if (ctrl_dram_bvld && (ctrl_dram_bid == id_q)) begin
                    if (ctrl_dram_bresp == 2'b00) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        clear_c = 1'b1;
                        state_d = S_AW;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_c) begin
            reads_d    = '0;
            beats_d    = '0;
            cnt_d      = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            inflight_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            daddr_q    <= '0;
            len_q      <= '0;
            size_q     <= '0;
            st_addr_q  <= '0;
            type_q     <= '0;
            reads_q    <= '0;
            beats_q    <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            retry_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            daddr_q    <= daddr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            st_addr_q  <= st_addr_d;
            type_q     <= type_d;
            reads_q    <= reads_d;
            beats_q    <= beats_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
        end
    end

    assign ctrl_store_rdy    = (state_q == S_IDLE);
    assign store_sram_vld    = read_en_c;
    assign store_sram_addr   = st_addr_q + SRAM_AW'(reads_q);
    assign store_sram_type   = type_q;
    assign store_axi_awid    = id_q;
    assign store_axi_awaddr  = daddr_q;
    assign store_axi_awlen   = len_q;
    assign store_axi_awsize  = size_q;
    assign store_axi_awburst = 2'b01;
    assign store_axi_awvld   = (state_q == S_AW);
    assign store_axi_wdata   = (fifo_empty_c && inflight_q) ? sram_store_dout : fifo_q[rd_ptr_q];
    assign store_axi_wstrb   = wvld_c ? strb_c : '0;
    assign store_axi_wlast   = wvld_c && last_beat_c;
    assign store_axi_wvld    = wvld_c;
    assign store_axi_brdy    = (state_q == S_RESP);
    assign store_done        = (state_q == S_DONE);
    assign store_err         = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: random AXI/SRAM traffic against a transaction-level model.
module tb_store_buffer;

    localparam int unsigned DW = 32, SRAM_AW = 8, DRAM_AW = 12, ID_W = 8, MAX_RETRY = 1;

    logic               clk, rst;
    logic               ctrl_store_vld, ctrl_store_rdy;
    logic [ID_W-1:0]    ctrl_store_id;
    logic [DRAM_AW-1:0] ctrl_store_dram_addr;
    logic [7:0]         ctrl_store_len;
    logic [2:0]         ctrl_store_size;
    logic [SRAM_AW-1:0] ctrl_store_st_addr;
    logic [1:0]         ctrl_store_sram_type;
    logic               store_sram_vld;
    logic [SRAM_AW-1:0] store_sram_addr;
    logic [1:0]         store_sram_type;
    logic [DW-1:0]      sram_store_dout;
    logic [ID_W-1:0]    store_axi_awid;
    logic [DRAM_AW-1:0] store_axi_awaddr;
    logic [7:0]         store_axi_awlen;
    logic [2:0]         store_axi_awsize;
    logic [1:0]         store_axi_awburst;
    logic               store_axi_awvld, ctrl_dram_awrdy;
    logic [DW-1:0]      store_axi_wdata;
    logic [DW/8-1:0]    store_axi_wstrb;
    logic               store_axi_wlast, store_axi_wvld, ctrl_dram_wrdy;
    logic [ID_W-1:0]    ctrl_dram_bid;
    logic [1:0]         ctrl_dram_bresp;
    logic               ctrl_dram_bvld, store_axi_brdy;
    logic               store_done, store_err;

    store_buffer #(.DW(DW), .SRAM_AW(SRAM_AW), .DRAM_AW(DRAM_AW), .ID_W(ID_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst),
        .ctrl_store_vld(ctrl_store_vld), .ctrl_store_rdy(ctrl_store_rdy),
        .ctrl_store_id(ctrl_store_id), .ctrl_store_dram_addr(ctrl_store_dram_addr),
        .ctrl_store_len(ctrl_store_len), .ctrl_store_size(ctrl_store_size),
        .ctrl_store_st_addr(ctrl_store_st_addr), .ctrl_store_sram_type(ctrl_store_sram_type),
        .store_sram_vld(store_sram_vld), .store_sram_addr(store_sram_addr),
        .store_sram_type(store_sram_type), .sram_store_dout(sram_store_dout),
        .store_axi_awid(store_axi_awid), .store_axi_awaddr(store_axi_awaddr),
        .store_axi_awlen(store_axi_awlen), .store_axi_awsize(store_axi_awsize),
        .store_axi_awburst(store_axi_awburst), .store_axi_awvld(store_axi_awvld),
        .ctrl_dram_awrdy(ctrl_dram_awrdy),
        .store_axi_wdata(store_axi_wdata), .store_axi_wstrb(store_axi_wstrb),
        .store_axi_wlast(store_axi_wlast), .store_axi_wvld(store_axi_wvld),
        .ctrl_dram_wrdy(ctrl_dram_wrdy),
        .ctrl_dram_bid(ctrl_dram_bid), .ctrl_dram_bresp(ctrl_dram_bresp),
        .ctrl_dram_bvld(ctrl_dram_bvld), .store_axi_brdy(store_axi_brdy),
        .store_done(store_done), .store_err(store_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM contents and a one-cycle read port
    logic [31:0] mem [4][256];
    always @(posedge clk) if (store_sram_vld) sram_store_dout <= mem[store_sram_type][store_sram_addr];

    function automatic logic [31:0] mem_rd(input int t, input int a);
        logic [1:0] tt;
        logic [7:0] aa;
        tt = t[1:0];
        aa = a[7:0];
        return mem[tt][aa];
    endfunction

    function automatic int strb_exp(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 15);
    endfunction

    // Transaction-level model state
    bit          m_active, m_aw_pend, m_aw_done, m_done_due, m_exp_err, m_prev_stall;
    int          m_beat, m_read, m_retries;
    logic [31:0] m_prev_wdata;
    int          c_id, c_daddr, c_len, c_size, c_st, c_type, acc_cyc;
    int          rec_reads[$];
    logic [31:0] rec_beats[$];
    int          rec_aw, rec_done, rec_err, lat_aw, lat_rd, lat_w;

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (rst) begin
            m_active = 0; m_aw_pend = 0; m_aw_done = 0; m_done_due = 0; m_prev_stall = 0;
        end else begin
            chk("rdy", 64'(ctrl_store_rdy), 64'(!m_active));
            chk("awvld", 64'(store_axi_awvld), 64'(m_aw_pend));
            chk("brdy", 64'(store_axi_brdy),
                64'(m_active && m_aw_done && !m_aw_pend && (m_beat == c_len + 1) && !m_done_due));
            chk("done", 64'(store_done), 64'(m_done_due));
            chk("err", 64'(store_err), 64'(m_done_due && m_exp_err));
            if (store_done && m_done_due) begin
                rec_done++; rec_err = int'(store_err);
                m_active = 0; m_done_due = 0; m_aw_done = 0;
            end
            if (store_sram_vld) begin
                chk("rd_allowed", 64'(m_aw_done && (m_read <= c_len) && (m_read - m_beat < 2)), 64'(1));
                chk("rd_addr", 64'(store_sram_addr), 64'((c_st + m_read) % 256));
                chk("rd_type", 64'(store_sram_type), 64'(c_type));
                rec_reads.push_back(int'(store_sram_addr));
                if (lat_rd < 0) lat_rd = cyc - acc_cyc;
                m_read++;
            end
            if (m_prev_stall) begin
                chk("w_hold_vld", 64'(store_axi_wvld), 64'(1));
                chk("w_hold_data", 64'(store_axi_wdata), 64'(m_prev_wdata));
            end
            if (store_axi_wvld) begin
                chk("w_allowed", 64'(m_aw_done && (m_beat <= c_len)), 64'(1));
                if (lat_w < 0) lat_w = cyc - acc_cyc;
                if (ctrl_dram_wrdy) begin
                    chk("wdata", 64'(store_axi_wdata), 64'(mem_rd(c_type, c_st + m_beat)));
                    chk("wlast", 64'(store_axi_wlast), 64'(m_beat == c_len));
                    chk("wstrb", 64'(store_axi_wstrb), 64'(strb_exp(c_size)));
                    rec_beats.push_back(store_axi_wdata);
                    m_beat++;
                end
            end
            m_prev_stall = store_axi_wvld && !ctrl_dram_wrdy;
            m_prev_wdata = store_axi_wdata;
            if (ctrl_dram_bvld && store_axi_brdy && (int'(ctrl_dram_bid) == c_id)) begin
                if (ctrl_dram_bresp == 2'b00) begin
                    m_done_due = 1; m_exp_err = 0;
                end else if (m_retries < int'(MAX_RETRY)) begin
                    m_retries++; m_aw_pend = 1; m_aw_done = 0;
                end else begin
                    m_done_due = 1; m_exp_err = 1;
                end
            end
            if (store_axi_awvld) begin
                chk("awid", 64'(store_axi_awid), 64'(c_id));
                chk("awaddr", 64'(store_axi_awaddr), 64'(c_daddr));
                chk("awlen", 64'(store_axi_awlen), 64'(c_len));
                chk("awsize", 64'(store_axi_awsize), 64'(c_size));
                chk("awburst", 64'(store_axi_awburst), 64'(2'b01));
                if (ctrl_dram_awrdy) begin
                    m_aw_pend = 0; m_aw_done = 1; m_beat = 0; m_read = 0; m_prev_stall = 0;
                    rec_aw++;
                    if (lat_aw < 0) lat_aw = cyc - acc_cyc;
                end
            end
            if (ctrl_store_vld && ctrl_store_rdy) begin
                c_id = int'(ctrl_store_id); c_daddr = int'(ctrl_store_dram_addr);
                c_len = int'(ctrl_store_len); c_size = int'(ctrl_store_size);
                c_st = int'(ctrl_store_st_addr); c_type = int'(ctrl_store_sram_type);
                m_active = 1; m_aw_pend = 1; m_aw_done = 0; m_done_due = 0; m_exp_err = 0;
                m_beat = 0; m_read = 0; m_retries = 0; m_prev_stall = 0;
                rec_reads.delete(); rec_beats.delete();
                rec_aw = 0; rec_done = 0; rec_err = -1;
                lat_aw = -1; lat_rd = -1; lat_w = -1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic idle_inputs();
        ctrl_store_vld = 0; ctrl_dram_awrdy = 0; ctrl_dram_wrdy = 0; ctrl_dram_bvld = 0;
        ctrl_dram_bid = '0; ctrl_dram_bresp = '0;
    endtask

    // One command; B responses follow a plan of nerr error responses (optionally
    // preceded by one with a foreign ID). abort=1 resets once W traffic starts.
    task automatic run_cmd(input logic [7:0] id, input logic [11:0] da, input logic [7:0] len,
                           input logic [2:0] sz, input logic [7:0] st, input logic [1:0] ty,
                           input bit stall, input int nerr, input bit wb, input bit abort);
        logic [7:0] pid[$];
        logic [1:0] prs[$];
        int  att, budget;
        bit  acc, hs_b, dn, aborted;
        att = (nerr > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : nerr + 1;
        for (int a = 0; a < att; a++) begin
            if (wb && a == 0) begin pid.push_back(id ^ 8'h01); prs.push_back(2'b10); end
            pid.push_back(id);
            prs.push_back((a < nerr) ? 2'b10 : 2'b00);
        end
        ctrl_store_id = id; ctrl_store_dram_addr = da; ctrl_store_len = len;
        ctrl_store_size = sz; ctrl_store_st_addr = st; ctrl_store_sram_type = ty;
        ctrl_store_vld = 1;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = ctrl_store_rdy;
            @(posedge clk); #1;
        end
        ctrl_store_vld = 0;
        ctrl_store_id = 8'($urandom); ctrl_store_len = 8'($urandom);
        ctrl_store_st_addr = 8'($urandom); ctrl_store_size = 3'($urandom);
        if (!acc) begin chk("accept_timeout", 64'(0), 64'(1)); return; end
        budget = 40 * (int'(len) + 1) + 200;
        dn = 0; aborted = 0;
        for (int k = 0; k < budget && !dn; k++) begin
            ctrl_dram_awrdy = stall ? ($urandom % 3 != 0) : 1'b1;
            ctrl_dram_wrdy  = stall ? ($urandom % 2 == 0) : 1'b1;
            if (store_axi_brdy && pid.size() > 0 && (!stall || $urandom % 2 == 0)) begin
                ctrl_dram_bvld = 1; ctrl_dram_bid = pid[0]; ctrl_dram_bresp = prs[0];
            end else begin
                ctrl_dram_bvld = 0; ctrl_dram_bid = 8'($urandom); ctrl_dram_bresp = 2'($urandom);
            end
            if (abort && store_axi_wvld) begin
                idle_inputs();
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                @(negedge clk);
                chk("abort_rdy", 64'(ctrl_store_rdy), 64'(1));
                chk("abort_awvld", 64'(store_axi_awvld), 64'(0));
                chk("abort_wvld", 64'(store_axi_wvld), 64'(0));
                chk("abort_done", 64'(store_done), 64'(0));
                repeat (5) @(negedge clk);
                @(posedge clk); #1;
                aborted = 1;
                break;
            end
            @(negedge clk);
            hs_b = ctrl_dram_bvld && store_axi_brdy;
            dn   = store_done;
            @(posedge clk); #1;
            if (hs_b) begin void'(pid.pop_front()); void'(prs.pop_front()); end
        end
        idle_inputs();
        if (!dn && !aborted) chk("done_timeout", 64'(0), 64'(1));
    endtask

    int wrap_exp[4] = '{254, 255, 0, 1};

    initial begin
        idle_inputs();
        ctrl_store_id = '0; ctrl_store_dram_addr = '0; ctrl_store_len = '0;
        ctrl_store_size = '0; ctrl_store_st_addr = '0; ctrl_store_sram_type = '0;
        rst = 1;
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 256; a++) mem[t][a] = $urandom;
        for (int i = 0; i < 4; i++) mem[0][16 + i] = 32'hA0 + 32'(i);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_rdy", 64'(ctrl_store_rdy), 64'(1));
        chk("rst_awburst", 64'(store_axi_awburst), 64'(2'b01));
        chk("rst_awvld", 64'(store_axi_awvld), 64'(0));
        chk("rst_wvld", 64'(store_axi_wvld), 64'(0));
        chk("rst_sram_vld", 64'(store_sram_vld), 64'(0));
        chk("rst_wdata", 64'(store_axi_wdata), 64'(0));
        chk("rst_wstrb", 64'(store_axi_wstrb), 64'(0));
        chk("rst_wlast", 64'(store_axi_wlast), 64'(0));
        chk("rst_brdy", 64'(store_axi_brdy), 64'(0));
        chk("rst_done", 64'(store_done), 64'(0));
        @(posedge clk); #1;

        // len=3 from 0x10, always-ready slave
        run_cmd(8'h05, 12'h100, 8'd3, 3'd2, 8'h10, 2'd0, 0, 0, 0, 0);
        chk("t1_nbeats", 64'(rec_beats.size()), 64'(4));
        for (int i = 0; i < 4 && i < rec_beats.size(); i++)
            chk("t1_beat", 64'(rec_beats[i]), 64'(32'hA0 + 32'(i)));
        chk("t1_aw", 64'(rec_aw), 64'(1));
        chk("t1_err", 64'(rec_err), 64'(0));

        // len=0 latency with no stalls
        run_cmd(8'h07, 12'h040, 8'd0, 3'd0, 8'h20, 2'd2, 0, 0, 0, 0);
        chk("t0_lat_aw", 64'(lat_aw), 64'(1));
        chk("t0_lat_rd", 64'(lat_rd), 64'(2));
        chk("t0_lat_w", 64'(lat_w), 64'(3));
        chk("t0_nbeats", 64'(rec_beats.size()), 64'(1));

        // same as first command with random W/AW/B stalls
        run_cmd(8'h05, 12'h100, 8'd3, 3'd2, 8'h10, 2'd0, 1, 0, 0, 0);
        chk("t2_nbeats", 64'(rec_beats.size()), 64'(4));
        for (int i = 0; i < 4 && i < rec_beats.size(); i++)
            chk("t2_beat", 64'(rec_beats[i]), 64'(32'hA0 + 32'(i)));

        // SRAM address wrap
        run_cmd(8'h11, 12'h200, 8'd3, 3'd1, 8'hFE, 2'd1, 0, 0, 0, 0);
        chk("t3_nreads", 64'(rec_reads.size()), 64'(4));
        for (int i = 0; i < 4 && i < rec_reads.size(); i++)
            chk("t3_rd_addr", 64'(rec_reads[i]), 64'(wrap_exp[i]));

        // one error then OKAY
        run_cmd(8'h22, 12'h300, 8'd3, 3'd2, 8'h10, 2'd0, 0, 1, 0, 0);
        chk("t4_aw", 64'(rec_aw), 64'(2));
        chk("t4_nbeats", 64'(rec_beats.size()), 64'(8));
        chk("t4_err", 64'(rec_err), 64'(0));

        // two errors plus a foreign-ID response: retry budget exhausted
        run_cmd(8'h33, 12'h310, 8'd3, 3'd2, 8'h10, 2'd0, 0, 2, 1, 0);
        chk("t5_aw", 64'(rec_aw), 64'(2));
        chk("t5_err", 64'(rec_err), 64'(1));
        chk("t5_done", 64'(rec_done), 64'(1));

        // reset mid-DATA, then a clean command
        run_cmd(8'h44, 12'h400, 8'd7, 3'd2, 8'h30, 2'd3, 1, 0, 0, 1);
        run_cmd(8'h45, 12'h480, 8'd2, 3'd2, 8'h40, 2'd3, 0, 0, 0, 0);
        chk("t6_done", 64'(rec_done), 64'(1));
        chk("t6_err", 64'(rec_err), 64'(0));

        // randomized commands
        for (int i = 0; i < 30; i++) begin
            run_cmd(8'($urandom), 12'($urandom), (i == 0) ? 8'd255 : 8'($urandom % 12),
                    3'($urandom), 8'($urandom), 2'($urandom),
                    1'($urandom % 2), int'($urandom % 3), 1'($urandom % 2), 0);
            chk("rand_done", 64'(rec_done), 64'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
